dpram_access_ctrl: RTL
======================

# dpram_access_ctrl

Two-port access controller sitting directly upstream of the dual-port RAM core and its per-port control registers. Accepts independent read/write requests on ports A and B with a valid/ready handshake, issues one-cycle registered chip-enable/write-enable/address/data strobes to the RAM, and returns read data with a valid/ready handshake. Resolves same-address conflicts between the two ports by stalling port B.

## Interface
- ADDR_W, 4, RAM address width
- DATA_W, 8, RAM data width
- RD_LAT, 1, RAM read latency in cycles from CE to valid read data (1..4)

Ports (x = a, b; one copy of each per-port signal):
- i_clk  in  1  single clock, all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_x_req  in  1  request valid
- o_x_ack  out  1  request ready; transfer occurs when i_x_req && o_x_ack
- i_x_we  in  1  1 = write, 0 = read; sampled with the transfer
- i_x_addr  in  ADDR_W  access address
- i_x_wdata  in  DATA_W  write data
- o_x_rdata  out  DATA_W  read response data
- o_x_rvalid  out  1  read response valid
- i_x_rready  in  1  read response accepted
- o_x_ce  out  1  RAM chip enable (registered)
- o_x_we  out  1  RAM write enable (registered)
- o_x_addr  out  ADDR_W  RAM address (registered)
- o_x_wdata  out  DATA_W  RAM write data (registered)
- i_x_ram_rdata  in  DATA_W  RAM read data
- o_coll_cnt  out  8  collision stall count (present only with DPRAM_COLL_CHK_EN)

## Operation
- Per-port FSM: IDLE, ISSUE, WAIT, RESP.
- IDLE: o_x_ack = 1 unless stalled; on transfer, latch we/addr/wdata into RAM-side registers, go ISSUE.
- ISSUE: o_x_ce = 1 for exactly this cycle, o_x_we = latched we. Write -> IDLE. Read -> WAIT.
- WAIT: count RD_LAT cycles from ISSUE; in the last one capture i_x_ram_rdata into o_x_rdata, go RESP.
- RESP: o_x_rvalid = 1, o_x_rdata stable until i_x_rready; on i_x_rready -> IDLE (rvalid low next cycle).
- o_x_ack is 0 in ISSUE, WAIT, RESP; no request queuing.
- o_x_ce low outside ISSUE; o_x_addr/o_x_wdata hold last values when ce low.
- Collision (macro on): transfers on both ports in the same cycle, i_a_addr == i_b_addr, and i_a_we || i_b_we -> o_b_ack forced 0 that cycle, only A accepted. B is accepted the following cycle if still requesting, so its ISSUE is one cycle after A's. Read/read at same address is not a collision.
- o_coll_cnt increments by 1 per stalled cycle, saturates at 255.
- Ports are otherwise fully independent.

## Timing
- Reset: every output 0, both FSMs IDLE, o_coll_cnt 0. o_x_ack gated by i_rst, so 0 during reset, 1 the first cycle after release.
- Reset mid-operation: aborts any access; no CE in the cycle after reset is asserted; pending rvalid drops; no response ever delivered.
- Write: transfer at cycle t, CE/WE at t+1, ack again at t+2 (1 write per 2 cycles).
- Read: transfer at t, CE at t+1, rdata captured at end of t+RD_LAT+1, rvalid from t+RD_LAT+2. With i_x_rready held high, ack again at t+RD_LAT+3.
- Request held with ack low keeps i_x_* stable; controller samples only on transfer.

## Configuration
- DPRAM_COLL_CHK_EN defined: collision detection, B stall and o_coll_cnt as above.
- Undefined: no comparison, no stall, o_b_ack purely FSM-based, o_coll_cnt port removed. Same-cycle same-address conflicts pass to the RAM unchanged and are the integrator's responsibility.

## Structure
- Package dpram_pkg: FSM state enum (IDLE, ISSUE, WAIT, RESP), default ADDR_W/DATA_W/RD_LAT constants, collision counter width 8.
- Sub-module dpram_port_fsm: one port's FSM, RAM-side registers, latency counter, response register; instantiated twice. Top holds collision compare, stall gating and counter.

## Test plan
- Reset release: all outputs 0 during i_rst; cycle after release o_a_ack = o_b_ack = 1, o_coll_cnt = 0.
- Port A write addr 3 data 0xA5 at t -> o_a_ce=1, o_a_we=1, o_a_addr=3, o_a_wdata=0xA5 at t+1 only; o_a_ack=1 at t+2.
- Port B read addr 3 (RAM returns 0xA5, RD_LAT=1), i_b_rready held low 3 cycles -> o_b_rvalid=1 with 0xA5 from t+3, stable until rready, low the cycle after.
- Same cycle A write addr 5 / B read addr 5, macro on -> o_b_ack=0, A ISSUE at t+1, B ISSUE at t+2, o_coll_cnt=1; macro off -> both ISSUE at t+1.
- Same cycle A read addr 7 / B read addr 7 -> both accepted, no stall, o_coll_cnt unchanged; A write 2 / B write 9 -> both ISSUE at t+1.
- i_rst asserted in WAIT of a port A read -> no o_a_rvalid ever, o_a_ce=0, FSM IDLE, o_a_ack=1 after release.

Source files
------------

// File: rtl/dpram_pkg.sv
// Shared types and default constants for the dual-port RAM access controller.
package dpram_pkg;

  localparam int unsigned DPRAM_ADDR_W = 4;
  localparam int unsigned DPRAM_DATA_W = 8;
  localparam int unsigned DPRAM_RD_LAT = 1;
  localparam int unsigned COLL_CNT_W   = 8;
  // Wide enough for RD_LAT up to 4.
  localparam int unsigned LAT_CNT_W    = 3;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } port_state_e;

endpackage

// File: rtl/dpram_access_ctrl_if.sv
// Per-port request/response bus between a requester and the access controller.
interface dpram_access_ctrl_if #(
  parameter int unsigned ADDR_W = dpram_pkg::DPRAM_ADDR_W,
  parameter int unsigned DATA_W = dpram_pkg::DPRAM_DATA_W
) ();

  logic              req;
  logic              ack;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              rready;

  modport master (
    output req, we, addr, wdata, rready,
    input  ack, rdata, rvalid
  );

  modport slave (
    input  req, we, addr, wdata, rready,
    output ack, rdata, rvalid
  );

endinterface

// File: rtl/dpram_port_fsm.sv
// One port of the access controller: IDLE/ISSUE/WAIT/RESP FSM, registered RAM strobes,
// read-latency counter and response register.
module dpram_port_fsm
  import dpram_pkg::*;
#(
  parameter int unsigned ADDR_W = DPRAM_ADDR_W,
  parameter int unsigned DATA_W = DPRAM_DATA_W,
  parameter int unsigned RD_LAT = DPRAM_RD_LAT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  output logic              o_ready,
  input  logic              i_ack,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rvalid,
  input  logic              i_rready,
  output logic              o_ce,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  port_state_e          r_state;
  port_state_e          w_state_nxt;
  logic [LAT_CNT_W-1:0] r_lat_cnt;
  logic                 w_xfer;
  logic                 w_lat_done;

  // i_ack is o_ready after any stall gating applied by the parent.
  assign w_xfer     = i_req & i_ack;
  assign w_lat_done = (r_lat_cnt == LAT_CNT_W'(RD_LAT - 1));

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_xfer) w_state_nxt = StIssue;
      StIssue: w_state_nxt = o_ram_we ? StIdle : StWait;
      StWait:  if (w_lat_done) w_state_nxt = StResp;
      StResp:  if (i_rready) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // FSM outputs; readiness is masked during reset so nothing is accepted then
  always_comb begin
    o_ready  = (r_state == StIdle) & ~i_rst;
    o_rvalid = (r_state == StResp);
  end

  // RAM-side strobes: CE/WE pulse for the single ISSUE cycle, address/data hold
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_ce        <= 1'b0;
      o_ram_we    <= 1'b0;
      o_ram_addr  <= '0;
      o_ram_wdata <= '0;
    end else begin
      o_ce     <= w_xfer;
      o_ram_we <= w_xfer & i_we;
      if (w_xfer) begin
        o_ram_addr  <= i_addr;
        o_ram_wdata <= i_wdata;
      end
    end
  end

  // Latency counter and read-data capture in the last WAIT cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lat_cnt <= '0;
      o_rdata   <= '0;
    end else if (r_state == StWait) begin
      r_lat_cnt <= w_lat_done ? '0 : r_lat_cnt + 1'b1;
      if (w_lat_done) o_rdata <= i_ram_rdata;
    end else begin
      r_lat_cnt <= '0;
    end
  end

endmodule

// File: rtl/dpram_access_ctrl.sv
// Two-port access controller in front of a dual-port RAM. Optional same-address
// collision stall of port B is enabled by defining DPRAM_COLL_CHK_EN.
module dpram_access_ctrl
  import dpram_pkg::*;
#(
  parameter int unsigned ADDR_W = DPRAM_ADDR_W,
  parameter int unsigned DATA_W = DPRAM_DATA_W,
  parameter int unsigned RD_LAT = DPRAM_RD_LAT
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
`ifdef DPRAM_COLL_CHK_EN
  output logic [COLL_CNT_W-1:0] o_coll_cnt,
`endif
  dpram_access_ctrl_if.slave    io_a,
  dpram_access_ctrl_if.slave    io_b,
  output logic                  o_a_ce,
  output logic                  o_a_we,
  output logic [ADDR_W-1:0]     o_a_addr,
  output logic [DATA_W-1:0]     o_a_wdata,
  input  logic [DATA_W-1:0]     i_a_ram_rdata,
  output logic                  o_b_ce,
  output logic                  o_b_we,
  output logic [ADDR_W-1:0]     o_b_addr,
  output logic [DATA_W-1:0]     o_b_wdata,
  input  logic [DATA_W-1:0]     i_b_ram_rdata
);

  logic w_a_ready;
  logic w_b_ready;
  logic w_b_stall;

`ifdef DPRAM_COLL_CHK_EN
  logic                  w_coll;
  logic [COLL_CNT_W-1:0] r_coll_cnt;

  // Both ports would transfer to the same address with at least one write: A wins
  assign w_coll = io_a.req & w_a_ready & io_b.req & w_b_ready &
                  (io_a.addr == io_b.addr) & (io_a.we | io_b.we);
  assign w_b_stall  = w_coll;
  assign o_coll_cnt = r_coll_cnt;

  // Saturating count of stalled cycles
  always_ff @(posedge i_clk) begin
    if (i_rst)                        r_coll_cnt <= '0;
    else if (w_coll && ~&r_coll_cnt) r_coll_cnt <= r_coll_cnt + 1'b1;
  end
`else
  assign w_b_stall = 1'b0;
`endif

  assign io_a.ack = w_a_ready;
  assign io_b.ack = w_b_ready & ~w_b_stall;

  dpram_port_fsm #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_port_a (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req       (io_a.req),
    .o_ready     (w_a_ready),
    .i_ack       (io_a.ack),
    .i_we        (io_a.we),
    .i_addr      (io_a.addr),
    .i_wdata     (io_a.wdata),
    .o_rdata     (io_a.rdata),
    .o_rvalid    (io_a.rvalid),
    .i_rready    (io_a.rready),
    .o_ce        (o_a_ce),
    .o_ram_we    (o_a_we),
    .o_ram_addr  (o_a_addr),
    .o_ram_wdata (o_a_wdata),
    .i_ram_rdata (i_a_ram_rdata)
  );

  dpram_port_fsm #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_port_b (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req       (io_b.req),
    .o_ready     (w_b_ready),
    .i_ack       (io_b.ack),
    .i_we        (io_b.we),
    .i_addr      (io_b.addr),
    .i_wdata     (io_b.wdata),
    .o_rdata     (io_b.rdata),
    .o_rvalid    (io_b.rvalid),
    .i_rready    (io_b.rready),
    .o_ce        (o_b_ce),
    .o_ram_we    (o_b_we),
    .o_ram_addr  (o_b_addr),
    .o_ram_wdata (o_b_wdata),
    .i_ram_rdata (i_b_ram_rdata)
  );

endmodule
